// File: rtl/pc_seq_unit_if.sv
// Control/status bundle between the control unit and the PC sequencer.
// master: control side (drives flow controls), slave: pc_seq_unit.
interface pc_seq_unit_if #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned OFFSET_WIDTH = 8
);
    logic                    stall;
    logic                    jump;
    logic                    branch;
    logic                    branch_ne;
    logic                    zero;
    logic                    call;
    logic                    ret;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [PC_WIDTH-1:0]     pc;
    logic                    ras_empty;
    logic                    ras_full;
    logic                    ras_err;

    modport master (
        output stall, jump, branch, branch_ne, zero, call, ret, offset,
        input  pc, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, jump, branch, branch_ne, zero, call, ret, offset,
        output pc, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential/jump/branch/call/return next-PC selection.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_seq_unit #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          OFFSET_WIDTH = 8,
    parameter int unsigned          INSTR_BYTES  = 4,
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_seq_unit_if.slave  bus
);
    localparam int unsigned SHIFT = $clog2(INSTR_BYTES);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] next_pc_c;
    logic [PC_WIDTH-1:0] pc_seq_c;
    logic [PC_WIDTH-1:0] offset_ext_c;
    logic [PC_WIDTH-1:0] target_c;
    logic                take_c;
    logic                ras_pop_c;
    logic                ras_hit_c;
    logic [PC_WIDTH-1:0] ras_top_c;

    // Offset counts instructions; sign-extend then scale to bytes.
    assign pc_seq_c     = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign offset_ext_c = PC_WIDTH'($signed(bus.offset));
    assign target_c     = pc_seq_c + (offset_ext_c << SHIFT);
    assign take_c       = bus.call | bus.jump
                        | (bus.branch & bus.zero)
                        | (bus.branch_ne & ~bus.zero);

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned          PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned          CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_next_c;
    logic [PTR_W-1:0]    top_ptr_c;
    logic [PTR_W-1:0]    ptr_inc_c;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_next_c;
    logic                err_q;
    logic                err_next_c;
    logic                empty_q;
    logic                full_q;
    logic                push_c;

    // wr_ptr names the next free slot; top of stack sits just below it.
    assign top_ptr_c = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
    assign ptr_inc_c = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    assign ras_pop_c = ~bus.stall & bus.ret;
    assign push_c    = ~bus.stall & bus.call & ~bus.ret;
    assign ras_hit_c = ~empty_q;
    assign ras_top_c = ras_mem[top_ptr_c];

    always_comb begin
        wr_ptr_next_c = wr_ptr_q;
        count_next_c  = count_q;
        err_next_c    = err_q;
        if (ras_pop_c) begin
            if (empty_q) begin
                err_next_c = 1'b1;
            end else begin
                wr_ptr_next_c = top_ptr_c;
                count_next_c  = count_q - CNT_W'(1);
            end
        end else if (push_c) begin
            // Push on full overwrites the oldest entry, which is the slot at wr_ptr.
            wr_ptr_next_c = ptr_inc_c;
            if (full_q) begin
                err_next_c = 1'b1;
            end else begin
                count_next_c = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_next_c;
            count_q  <= count_next_c;
            err_q    <= err_next_c;
            empty_q  <= (count_next_c == '0);
            full_q   <= (count_next_c == CNT_MAX);
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            ras_mem[wr_ptr_q] <= pc_seq_c;
        end
    end

    assign bus.ras_empty = empty_q;
    assign bus.ras_full  = full_q;
    assign bus.ras_err   = err_q;
`else
    assign ras_pop_c     = 1'b0;
    assign ras_hit_c     = 1'b0;
    assign ras_top_c     = '0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif

    // Priority: stall, return, call/jump/taken branch, sequential.
    always_comb begin
        next_pc_c = pc_seq_c;
        if (bus.stall) begin
            next_pc_c = pc_q;
        end else if (ras_pop_c) begin
            next_pc_c = ras_hit_c ? ras_top_c : pc_seq_c;
        end else if (take_c) begin
            next_pc_c = target_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= next_pc_c;
        end
    end

    assign bus.pc = pc_q;
endmodule
